gpio_output: RTL

- Digital-output (DO) driver for the PLC I/O subsystem. It is the output-side counterpart of the synchronized DI capture path.
- Holds the commanded output image, which software updates through write/set/clear/toggle commands.
- Overlays timed one-shot pulses on selected channels.
- Forces all pins to a configured safe pattern when the output watchdog expires.
- Registered outputs drive the GPIO pads directly.

---
 rtl/gpio_output_pkg.sv | 17 +
 rtl/gpio_out_wdt.sv | 66 ++++++
 rtl/gpio_output.sv | 105 ++++++++++
 3 files changed

// File: rtl/gpio_output_pkg.sv
// Shared encodings for the digital-output driver: command opcodes and watchdog states.
package gpio_output_pkg;

    typedef enum logic [1:0] {
        DO_OP_WRITE  = 2'b00,
        DO_OP_SET    = 2'b01,
        DO_OP_CLEAR  = 2'b10,
        DO_OP_TOGGLE = 2'b11
    } do_op_e;

    typedef enum logic [1:0] {
        WDT_DISABLED = 2'b00,
        WDT_ARMED    = 2'b01,
        WDT_TRIPPED  = 2'b10
    } wdt_state_e;

endpackage

// File: rtl/gpio_out_wdt.sv
// Output watchdog: counts while armed, trips into a sticky state that only wdt_clear leaves.
module gpio_out_wdt
    import gpio_output_pkg::*;
#(
    parameter int unsigned WDT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WDT_W-1:0] timeout,
    input  logic             kick,
    input  logic             clear,
    output logic             tripped,
    output logic             trip_event
);

    wdt_state_e       state_q;
    logic [WDT_W-1:0] cnt_q;
    logic [WDT_W-1:0] thr;
    logic             hit;

    // A zero timeout is treated as one cycle.
    assign thr = (timeout == '0) ? WDT_W'(1) : timeout;
    assign hit = (cnt_q == thr - WDT_W'(1));

    // Asserted in the cycle whose closing edge enters TRIPPED; kick wins over the threshold.
    assign trip_event = (state_q == WDT_ARMED) && enable && !kick && hit;

    assign tripped = (state_q == WDT_TRIPPED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WDT_DISABLED;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                WDT_DISABLED: begin
                    cnt_q <= '0;
                    if (enable) state_q <= WDT_ARMED;
                end
                WDT_ARMED: begin
                    if (!enable) begin
                        state_q <= WDT_DISABLED;
                        cnt_q   <= '0;
                    end else if (kick) begin
                        cnt_q <= '0;
                    end else if (hit) begin
                        state_q <= WDT_TRIPPED;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + WDT_W'(1);
                    end
                end
                WDT_TRIPPED: begin
                    cnt_q <= '0;
                    if (clear) state_q <= WDT_DISABLED;
                end
                default: begin
                    state_q <= WDT_DISABLED;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/gpio_output.sv
// Digital-output driver: commanded image, one-shot pulse overlay and watchdog safe-state forcing.
module gpio_output
    import gpio_output_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned WDT_W   = 24,
    parameter int unsigned PULSE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_data,
    input  logic               pulse_valid,
    input  logic [WIDTH-1:0]   pulse_mask,
    input  logic [PULSE_W-1:0] pulse_len,
    input  logic               wdt_enable,
    input  logic [WDT_W-1:0]   wdt_timeout,
    input  logic               wdt_kick,
    input  logic               wdt_clear,
    input  logic [WIDTH-1:0]   safe_value,
    output logic [WIDTH-1:0]   gpio_o,
    output logic [WIDTH-1:0]   do_status,
    output logic               pulse_busy,
    output logic               wdt_tripped
);

    logic [WIDTH-1:0]   do_q, do_d;
    logic [WIDTH-1:0]   pmask_q, pmask_d;
    logic [PULSE_W-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0]   gpio_q, gpio_d;
    logic               busy_q;
    logic               tripped;
    logic               trip_event;
    logic               tripped_next;

    gpio_out_wdt #(
        .WDT_W (WDT_W)
    ) u_wdt (
        .clk        (clk),
        .rst        (rst),
        .enable     (wdt_enable),
        .timeout    (wdt_timeout),
        .kick       (wdt_kick),
        .clear      (wdt_clear),
        .tripped    (tripped),
        .trip_event (trip_event)
    );

    assign tripped_next = (tripped && !wdt_clear) || trip_event;

    always_comb begin
        do_d = do_q;
        if (cmd_valid) begin
            unique case (do_op_e'(cmd_op))
                DO_OP_WRITE:  do_d = cmd_data;
                DO_OP_SET:    do_d = do_q | cmd_data;
                DO_OP_CLEAR:  do_d = do_q & ~cmd_data;
                DO_OP_TOGGLE: do_d = do_q ^ cmd_data;
                default:      do_d = do_q;
            endcase
        end
    end

    // Tripping flushes the pulse; new pulses are refused while tripped.
    always_comb begin
        pmask_d = pmask_q;
        pcnt_d  = pcnt_q;
        if (trip_event) begin
            pmask_d = '0;
            pcnt_d  = '0;
        end else if (pulse_valid && (pulse_len != '0) && !tripped) begin
            pmask_d = pulse_mask;
            pcnt_d  = pulse_len;
        end else if (pcnt_q != '0) begin
            pcnt_d = pcnt_q - PULSE_W'(1);
        end
    end

    always_comb begin
        gpio_d = tripped_next ? safe_value : (do_d | ((pcnt_d != '0) ? pmask_d : '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            do_q    <= '0;
            pmask_q <= '0;
            pcnt_q  <= '0;
            gpio_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            do_q    <= do_d;
            pmask_q <= pmask_d;
            pcnt_q  <= pcnt_d;
            gpio_q  <= gpio_d;
            busy_q  <= (pcnt_d != '0);
        end
    end

    assign gpio_o      = gpio_q;
    assign do_status   = do_q;
    assign pulse_busy  = busy_q;
    assign wdt_tripped = tripped;

endmodule
